fnd_scan_driver: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display (FND). It takes four BCD digits and per-digit decimal points from the watch/stopwatch datapath, generates its own scan tick and digit select, and drives the active-low common and segment pins. The block sits between the display-formatting logic and the top-level FND pins, and is the sole consumer of display data.

---
 rtl/fnd_pkg.sv | 30 +++
 rtl/fnd_scan_driver_if.sv | 22 ++
 rtl/fnd_font_decoder.sv | 26 ++
 rtl/fnd_scan_driver.sv | 102 ++++++++++
 tb/tb_fnd_scan_driver.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the seven-segment display path: digit count, segment
// bit order and the active-low font table.
package fnd_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Segment bit positions within fnd_font: {dp,g,f,e,d,c,b,a}
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

endpackage

// File: rtl/fnd_scan_driver_if.sv
// Display data in, FND pins out. The datapath is the master; the scan driver
// is the slave.
interface fnd_scan_driver_if;

  logic [15:0] i_bcd;
  logic [3:0]  i_dp;
  logic        i_blank_lz;
  logic        i_update;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_font;

  modport master (
    output i_bcd, i_dp, i_blank_lz, i_update,
    input  fnd_com, fnd_font
  );

  modport slave (
    input  i_bcd, i_dp, i_blank_lz, i_update,
    output fnd_com, fnd_font
  );

endinterface

// File: rtl/fnd_font_decoder.sv
// BCD digit to active-low a..g segments; codes 10..15 render as a dash.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = FONT_DASH[SEG_G:SEG_A];
    case (i_bcd)
      4'd0:    o_seg = FONT_0[SEG_G:SEG_A];
      4'd1:    o_seg = FONT_1[SEG_G:SEG_A];
      4'd2:    o_seg = FONT_2[SEG_G:SEG_A];
      4'd3:    o_seg = FONT_3[SEG_G:SEG_A];
      4'd4:    o_seg = FONT_4[SEG_G:SEG_A];
      4'd5:    o_seg = FONT_5[SEG_G:SEG_A];
      4'd6:    o_seg = FONT_6[SEG_G:SEG_A];
      4'd7:    o_seg = FONT_7[SEG_G:SEG_A];
      4'd8:    o_seg = FONT_8[SEG_G:SEG_A];
      4'd9:    o_seg = FONT_9[SEG_G:SEG_A];
      default: o_seg = FONT_DASH[SEG_G:SEG_A];
    endcase
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed 4-digit common-anode FND driver with shadowed display data,
// per-slot anti-ghosting guard and optional leading-zero blanking.
module fnd_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned GUARD    = 1000
) (
  input  logic              clk,
  input  logic              reset,
  fnd_scan_driver_if.slave  bus
);

  import fnd_pkg::*;

  localparam int unsigned          DIV_W     = $clog2(SCAN_DIV);
  localparam int unsigned          IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]     GUARD_END = DIV_W'(GUARD);

  if (SCAN_DIV < 4 || GUARD < 1 || GUARD >= SCAN_DIV) begin : g_param_check
    $error("fnd_scan_driver: SCAN_DIV must be >= 4 and 1 <= GUARD < SCAN_DIV");
  end

  logic [15:0]      r_bcd;
  logic [3:0]       r_dp;
  logic             r_blank_lz;
  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_com;
  logic [7:0]       r_font;

  logic [3:0]       w_digit;
  logic [6:0]       w_seg;
  logic [3:0]       w_blank;
  logic             w_run;
  logic [3:0]       w_com_d;
  logic [7:0]       w_font_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd      <= '0;
      r_dp       <= '0;
      r_blank_lz <= 1'b0;
    end else if (bus.i_update) begin
      r_bcd      <= bus.i_bcd;
      r_dp       <= bus.i_dp;
      r_blank_lz <= bus.i_blank_lz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_comb begin
    w_digit = r_bcd[{r_idx, 2'b00} +: 4];
  end

  fnd_font_decoder u_font_decoder (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // A digit blanks only while it and every digit above it are zero; codes
  // 10..15 are non-zero, so they stop the blanking run.
  always_comb begin
    w_blank = '0;
    w_run   = r_blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_run      = w_run & (r_bcd[4*k +: 4] == 4'd0);
      w_blank[k] = w_run;
    end
  end

  always_comb begin
    w_font_d               = FONT_BLANK;
    w_font_d[SEG_G:SEG_A]  = w_blank[r_idx] ? FONT_BLANK[SEG_G:SEG_A] : w_seg;
    w_font_d[SEG_DP]       = ~r_dp[r_idx];
    w_com_d                = (r_div < GUARD_END) ? 4'b1111 : ~(4'(1) << r_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_com  <= 4'b1111;
      r_font <= FONT_BLANK;
    end else begin
      r_com  <= w_com_d;
      r_font <= w_font_d;
    end
  end

  assign bus.fnd_com  = r_com;
  assign bus.fnd_font = r_font;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver with SCAN_DIV=8, GUARD=2.
module tb_fnd_scan_driver;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned GUARD    = 2;
  localparam int unsigned LIT      = SCAN_DIV - GUARD;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  fnd_scan_driver_if bus ();

  fnd_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][7:0] font;  // font[k] = expected pins for digit k
  } vec_t;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] font;
  } sb_t;

  vec_t vecs[9];
  sb_t  sbq[$];

  int n_pass  = 0;
  int n_total = 0;

  bit         chk_en   = 1'b0;
  bit         prev_lit = 1'b0;
  int         lit_run  = 0;
  int         guard_run = 0;
  int         nxt      = 0;
  int         cur      = 0;
  logic [3:0] run_com  = 4'hF;
  int         lit_cnt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle monitor: slot timing, digit order and scoreboard pops.
  task automatic sample();
    logic       lit;
    logic [3:0] exp_com;
    sb_t        e;
    lit = (bus.fnd_com != 4'hF);
    if (!chk_en) begin
      prev_lit  = 1'b0;
      lit_run   = 0;
      guard_run = 0;
      nxt       = 0;
      return;
    end
    if (lit) begin
      if (!prev_lit) begin
        chk("guard_len", guard_run, GUARD);
        exp_com = 4'b0001 << nxt;
        exp_com = ~exp_com;
        chk("digit_order", bus.fnd_com, exp_com);
        cur     = nxt;
        nxt     = (nxt + 1) % 4;
        lit_run = 1;
        run_com = bus.fnd_com;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("sb_com", bus.fnd_com, e.com);
          chk("sb_font", bus.fnd_font, e.font);
        end
      end else begin
        lit_run++;
        chk("com_stable", bus.fnd_com, run_com);
      end
      lit_cnt[cur]++;
    end else begin
      if (prev_lit) begin
        chk("lit_len", lit_run, LIT);
        guard_run = 1;
      end else begin
        guard_run++;
      end
    end
    prev_lit = lit;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic wait_com(input logic [3:0] t);
    int i;
    for (i = 0; i < 100; i++) begin
      tick();
      if (bus.fnd_com === t) break;
    end
    chk("wait_com", (i < 100), 1);
  endtask

  task automatic wait_frame_start();
    wait_com(4'b0111);
    wait_com(4'b1111);
  endtask

  task automatic update(input logic [15:0] bcd, input logic [3:0] dp, input logic blz);
    bus.i_bcd      = bcd;
    bus.i_dp       = dp;
    bus.i_blank_lz = blz;
    bus.i_update   = 1'b1;
    tick();
    bus.i_update   = 1'b0;
  endtask

  initial begin
    int         base[4];
    logic [3:0] c;
    sb_t        s;

    bus.i_bcd      = '0;
    bus.i_dp       = '0;
    bus.i_blank_lz = 1'b0;
    bus.i_update   = 1'b0;
    for (int k = 0; k < 4; k++) lit_cnt[k] = 0;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 32'hF9A4B099};
    vecs[1] = '{16'h0056, 4'b0000, 1'b1, 32'hFFFF9282};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
    vecs[3] = '{16'h0A05, 4'b0100, 1'b1, 32'hFF3FC092};
    vecs[4] = '{16'h7890, 4'b1111, 1'b0, 32'h78001040};
    vecs[5] = '{16'hFEDC, 4'b0000, 1'b1, 32'hBFBFBFBF};
    vecs[6] = '{16'h0000, 4'b1111, 1'b1, 32'h7F7F7F40};
    vecs[7] = '{16'h0000, 4'b0000, 1'b0, 32'hC0C0C0C0};
    vecs[8] = '{16'h0506, 4'b0000, 1'b1, 32'hFF92C082};

    // Reset state and first lit digit
    tick();
    tick();
    chk("rst_com", bus.fnd_com, 4'hF);
    chk("rst_font", bus.fnd_font, 8'hFF);
    reset = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    tick();
    chk("boot_guard0", bus.fnd_com, 4'hF);
    tick();
    chk("boot_guard1", bus.fnd_com, 4'hF);
    tick();
    chk("boot_com", bus.fnd_com, 4'b1110);
    chk("boot_font", bus.fnd_font, 8'hC0);

    // Mid-slot update: visible one clk after the strobe edge
    update(16'h0001, 4'b0000, 1'b0);
    wait_frame_start();
    tick();
    tick();
    chk("mid_pre_com", bus.fnd_com, 4'b1110);
    chk("mid_pre_font", bus.fnd_font, 8'hF9);
    update(16'h0009, 4'b0000, 1'b0);
    chk("mid_n_com", bus.fnd_com, 4'b1110);
    chk("mid_n_font", bus.fnd_font, 8'hF9);
    tick();
    chk("mid_n1_com", bus.fnd_com, 4'b1110);
    chk("mid_n1_font", bus.fnd_font, 8'h90);

    // Update landing on the slot wrap edge
    wait_frame_start();
    for (int i = 0; i < 6; i++) tick();
    update(16'h0040, 4'b0000, 1'b0);
    chk("wrap_old_com", bus.fnd_com, 4'b1110);
    chk("wrap_old_font", bus.fnd_font, 8'h90);
    tick();
    chk("wrap_new_com", bus.fnd_com, 4'hF);
    chk("wrap_new_font", bus.fnd_font, 8'h99);

    // Reset at div=5 of digit 2, with an update attempted during reset
    wait_com(4'b1011);
    tick();
    tick();
    reset  = 1'b1;
    chk_en = 1'b0;
    #1;
    chk("mrst_com", bus.fnd_com, 4'hF);
    chk("mrst_font", bus.fnd_font, 8'hFF);
    bus.i_bcd    = 16'h1234;
    bus.i_update = 1'b1;
    tick();
    tick();
    chk("mrst_hold_com", bus.fnd_com, 4'hF);
    bus.i_update = 1'b0;
    reset        = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    tick();
    chk("mrst_g0", bus.fnd_com, 4'hF);
    tick();
    chk("mrst_g1", bus.fnd_com, 4'hF);
    tick();
    chk("mrst_lit_com", bus.fnd_com, 4'b1110);
    chk("mrst_lit_font", bus.fnd_font, 8'hC0);

    // Table-driven frames through the scoreboard
    for (int v = 0; v < 9; v++) begin
      update(vecs[v].bcd, vecs[v].dp, vecs[v].blz);
      wait_frame_start();
      for (int k = 0; k < 4; k++) begin
        c      = 4'b0001 << k;
        s.com  = ~c;
        s.font = vecs[v].font[k];
        sbq.push_back(s);
      end
      for (int i = 0; i < 40 && sbq.size() > 0; i++) tick();
      chk("sb_drain", sbq.size(), 0);
      sbq.delete();
    end

    // 1000 frames with random updates
    wait_frame_start();
    for (int k = 0; k < 4; k++) base[k] = lit_cnt[k];
    for (int i = 0; i < 32 * 1000; i++) begin
      if ($urandom_range(7) == 0) begin
        bus.i_bcd      = 16'($urandom);
        bus.i_dp       = 4'($urandom);
        bus.i_blank_lz = 1'($urandom);
        bus.i_update   = 1'b1;
      end else begin
        bus.i_update   = 1'b0;
      end
      tick();
    end
    bus.i_update = 1'b0;
    for (int k = 0; k < 4; k++) chk("lit_total", lit_cnt[k] - base[k], 6 * 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
